dpram_pipe: RTL and testbench

Parametrised true dual-port RAM, the successor to our fixed 8-bit/256-entry dual-port RAM. Adds configurable width and depth, per-port enables, read-valid strobes, an optional output pipeline stage, a defined cross-port read-during-write mode, write-write collision arbitration with a flag, and a post-reset memory-clear sequence. Sits anywhere two independent agents share a buffer, for example as a DMA/CPU mailbox or a ping-pong frame store.

---
 rtl/dpram_pkg.sv | 12 +
 rtl/dpram_port_pipe.sv | 58 +++++
 rtl/dpram_pipe.sv | 161 ++++++++++++++++
 tb/tb_dpram_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared constants and FSM encoding for the parametrised dual-port RAM.
package dpram_pkg;

    localparam int unsigned RD_READ_FIRST  = 0;
    localparam int unsigned RD_WRITE_FIRST = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/dpram_port_pipe.sv
// Per-port read return path: read-data/valid registers, optional output stage, out-of-range zeroing.
module dpram_port_pipe
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              zero,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    // First stage: data register only loads on a read so dout holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd;
            if (rd) begin
                s1_data <= zero ? '0 : data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign dout  = s2_data;
            assign valid = s2_valid;
        end else begin : g_direct
            assign dout  = s1_data;
            assign valid = s1_valid;
        end
    endgenerate

endmodule

// File: rtl/dpram_pipe.sv
// True dual-port RAM with post-reset clear, collision arbitration and configurable read-during-write.
module dpram_pipe
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 2 ** ADDR_W,
    parameter int unsigned RD_MODE = RD_READ_FIRST,
    parameter int unsigned OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              valid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              valid_b,
    output logic              busy,
    output logic              collision
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] clr_ptr_nxt;
    logic              clr_we_c;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_a_c;
    logic              in_b_c;
    logic              acc_a_c;
    logic              acc_b_c;
    logic              wr_a_c;
    logic              wr_b_c;
    logic              rd_a_c;
    logic              rd_b_c;
    logic              coll_c;
    logic [IDX_W-1:0]  idx_a_c;
    logic [IDX_W-1:0]  idx_b_c;
    logic [DATA_W-1:0] rdata_a_c;
    logic [DATA_W-1:0] rdata_b_c;

    // State register; busy is registered alongside the state it mirrors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
            busy    <= (state_nxt == ST_CLEAR);
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_we_c    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we_c    = !rst;
                clr_ptr_nxt = clr_ptr + ADDR_W'(1);
                if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nxt   = ST_RUN;
                    clr_ptr_nxt = '0;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Request qualification: only in RUN, never on a reset edge, writes only in range.
    assign in_a_c  = ({1'b0, addr_a} < (ADDR_W + 1)'(DEPTH));
    assign in_b_c  = ({1'b0, addr_b} < (ADDR_W + 1)'(DEPTH));
    assign acc_a_c = en_a && !rst && (state == ST_RUN);
    assign acc_b_c = en_b && !rst && (state == ST_RUN);
    assign wr_a_c  = acc_a_c && we_a && in_a_c;
    assign wr_b_c  = acc_b_c && we_b && in_b_c;
    assign rd_a_c  = acc_a_c && !we_a;
    assign rd_b_c  = acc_b_c && !we_b;
    assign coll_c  = wr_a_c && wr_b_c && (addr_a == addr_b);
    assign idx_a_c = in_a_c ? IDX_W'(addr_a) : '0;
    assign idx_b_c = in_b_c ? IDX_W'(addr_b) : '0;

    // Cross-port read-during-write: array read gives old data, bypass gives new.
    always_comb begin
        rdata_a_c = mem[idx_a_c];
        rdata_b_c = mem[idx_b_c];
        if ((RD_MODE == RD_WRITE_FIRST) && wr_b_c && (addr_b == addr_a)) begin
            rdata_a_c = din_b;
        end
        if ((RD_MODE == RD_WRITE_FIRST) && wr_a_c && (addr_a == addr_b)) begin
            rdata_b_c = din_a;
        end
    end

    // Storage is never reset directly; the CLEAR walk zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[IDX_W'(clr_ptr)] <= '0;
        end else begin
            if (wr_b_c && !coll_c) begin
                mem[idx_b_c] <= din_b;
            end
            if (wr_a_c) begin
                mem[idx_a_c] <= din_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision <= 1'b0;
        end else begin
            collision <= coll_c;
        end
    end

    dpram_port_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_port_a (
        .clk   (clk),
        .rst   (rst),
        .rd    (rd_a_c),
        .zero  (!in_a_c),
        .data  (rdata_a_c),
        .dout  (dout_a),
        .valid (valid_a)
    );

    dpram_port_pipe #(
        .DATA_W  (DATA_W),
        .OUT_REG (OUT_REG)
    ) u_port_b (
        .clk   (clk),
        .rst   (rst),
        .rd    (rd_b_c),
        .zero  (!in_b_c),
        .data  (rdata_b_c),
        .dout  (dout_b),
        .valid (valid_b)
    );

endmodule

// File: tb/tb_dpram_pipe.sv
// Bench for dpram_pipe: two configurations share one stimulus stream, each checked against its own memory model.
module tb_dpram_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [3:0] addr_a = '0, addr_b = '0;
    logic [7:0] din_a = '0, din_b = '0;

    logic [7:0] dout_a_o [2];
    logic [7:0] dout_b_o [2];
    logic       valid_a_o [2];
    logic       valid_b_o [2];
    logic       busy_o [2];
    logic       coll_o [2];

    always #5 clk = ~clk;

    dpram_pipe #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a_o[0]), .valid_a(valid_a_o[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b_o[0]), .valid_b(valid_b_o[0]),
        .busy(busy_o[0]), .collision(coll_o[0])
    );

    dpram_pipe #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_MODE(1), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a_o[1]), .valid_a(valid_a_o[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b_o[1]), .valid_b(valid_b_o[1]),
        .busy(busy_o[1]), .collision(coll_o[1])
    );

    // Model configuration per DUT
    int depth_m  [2] = '{16, 12};
    int rdmode_m [2] = '{0, 1};
    int outreg_m [2] = '{0, 1};

    typedef struct {
        int         d;
        int         p;
        int         due;
        logic [7:0] data;
    } pend_t;

    pend_t      pq [$];
    logic [7:0] mem_m [2][16];
    int         clr_left [2];
    logic [7:0] e_dout [2][2];
    logic       e_valid [2][2];
    logic       e_coll [2];
    int         bcnt [2];
    int         k = 0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    // Apply the rules of one clock edge to both models using the inputs the DUTs just sampled.
    task automatic model_edge();
        logic       en [2];
        logic       we [2];
        int         ad [2];
        logic [7:0] dn [2];
        logic [7:0] val;
        logic       wr [2];
        int         o;
        en[0] = en_a; we[0] = we_a; ad[0] = int'(addr_a); dn[0] = din_a;
        en[1] = en_b; we[1] = we_b; ad[1] = int'(addr_b); dn[1] = din_b;
        k++;
        if (rst) pq.delete();
        for (int d = 0; d < 2; d++) begin
            e_coll[d] = 1'b0;
            e_valid[d][0] = 1'b0;
            e_valid[d][1] = 1'b0;
            if (rst) begin
                clr_left[d] = depth_m[d];
                e_dout[d][0] = '0;
                e_dout[d][1] = '0;
            end else if (clr_left[d] > 0) begin
                clr_left[d]--;
                if (clr_left[d] == 0) begin
                    for (int i = 0; i < 16; i++) mem_m[d][i] = '0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    o = 1 - p;
                    wr[p] = en[p] && we[p] && (ad[p] < depth_m[d]);
                end
                for (int p = 0; p < 2; p++) begin
                    o = 1 - p;
                    if (en[p] && !we[p]) begin
                        if (ad[p] >= depth_m[d]) val = '0;
                        else if (rdmode_m[d] == 1 && wr[o] && ad[o] == ad[p]) val = dn[o];
                        else val = mem_m[d][ad[p]];
                        pq.push_back('{d, p, k + outreg_m[d], val});
                    end
                end
                if (wr[0] && wr[1] && ad[0] == ad[1]) e_coll[d] = 1'b1;
                if (wr[1]) mem_m[d][ad[1]] = dn[1];
                if (wr[0]) mem_m[d][ad[0]] = dn[0];
            end
        end
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].due == k) begin
                e_valid[pq[i].d][pq[i].p] = 1'b1;
                e_dout[pq[i].d][pq[i].p]  = pq[i].data;
                pq.delete(i);
            end
        end
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_dout_a", d), 32'(dout_a_o[d]), 32'(e_dout[d][0]));
            check($sformatf("d%0d_valid_a", d), 32'(valid_a_o[d]), 32'(e_valid[d][0]));
            check($sformatf("d%0d_dout_b", d), 32'(dout_b_o[d]), 32'(e_dout[d][1]));
            check($sformatf("d%0d_valid_b", d), 32'(valid_b_o[d]), 32'(e_valid[d][1]));
            check($sformatf("d%0d_busy", d), 32'(busy_o[d]), 32'(clr_left[d] > 0));
            check($sformatf("d%0d_collision", d), 32'(coll_o[d]), 32'(e_coll[d]));
            if (busy_o[d] === 1'b1) bcnt[d]++;
        end
    endtask

    task automatic cyc(input logic r,
                       input logic ea, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                       input logic eb, input logic wb, input logic [3:0] ab, input logic [7:0] db);
        @(negedge clk);
        rst = r;
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        @(posedge clk);
        #1;
        model_edge();
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic rd_a(input logic [3:0] a);
        cyc(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    endtask

    initial begin
        logic       r, ea, wa, eb, wb;
        logic [3:0] aa, ab;
        logic [7:0] da, db;

        // Initial reset and clear
        cyc(1'b1, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        cyc(1'b1, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        idle(17);

        // Pre-write, reset again, write during busy, measure clear length
        cyc(1'b0, 1, 1, 4'd3, 8'hAA, 0, 0, 4'd0, 8'h00);
        rd_a(4'd3);
        idle(2);
        bcnt[0] = 0;
        bcnt[1] = 0;
        cyc(1'b1, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        idle(2);
        cyc(1'b0, 1, 1, 4'd3, 8'h55, 1, 0, 4'd3, 8'h00);
        idle(17);
        check("busy_len_d0", 32'(bcnt[0]), 32'd16);
        check("busy_len_d1", 32'(bcnt[1]), 32'd12);
        rd_a(4'd3);
        idle(2);

        // Independent ports
        cyc(1'b0, 1, 1, 4'd1, 8'h01, 1, 1, 4'd4, 8'h05);
        cyc(1'b0, 1, 0, 4'd1, 8'h00, 1, 0, 4'd4, 8'h00);
        idle(2);

        // Same-address dual write
        cyc(1'b0, 1, 1, 4'd7, 8'h11, 1, 1, 4'd7, 8'h22);
        rd_a(4'd7);
        idle(2);

        // Cross-port read during write
        cyc(1'b0, 1, 1, 4'd9, 8'h33, 0, 0, 4'd0, 8'h00);
        cyc(1'b0, 1, 1, 4'd9, 8'h44, 1, 0, 4'd9, 8'h00);
        idle(2);

        // Streaming reads, then a dual read of one address
        for (int i = 0; i < 8; i++) rd_a(4'(i));
        cyc(1'b0, 1, 0, 4'd9, 8'h00, 1, 0, 4'd9, 8'h00);
        idle(3);

        // Reset while reads are in flight
        for (int i = 0; i < 4; i++) rd_a(4'(i));
        cyc(1'b1, 1, 0, 4'd5, 8'h00, 1, 0, 4'd6, 8'h00);
        idle(18);

        // Out-of-range access on the 12-deep instance
        rd_a(4'd13);
        cyc(1'b0, 0, 0, 4'd0, 8'h00, 1, 1, 4'd13, 8'h77);
        rd_a(4'd13);
        cyc(1'b0, 1, 1, 4'd13, 8'h66, 1, 0, 4'd13, 8'h00);
        idle(3);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            ea = ($urandom_range(0, 3) != 0);
            eb = ($urandom_range(0, 3) != 0);
            wa = $urandom_range(0, 1) == 1;
            wb = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 1) == 1) begin
                aa = 4'($urandom_range(0, 3));
                ab = 4'($urandom_range(0, 3));
            end else begin
                aa = 4'($urandom_range(0, 15));
                ab = 4'($urandom_range(0, 15));
            end
            da = 8'($urandom);
            db = 8'($urandom);
            cyc(r, ea, wa, aa, da, eb, wb, ab, db);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
